// File: rtl/if_id_pipe_reg_if.sv
// Handshake and decoded-field bundle between fetch, the IF/ID register and decode.
// The master side is the upstream/downstream environment; the slave side is the pipe register.
interface if_id_pipe_reg_if #(
    parameter int unsigned INSTR_W = 8,
    parameter int unsigned OP_W    = 2,
    parameter int unsigned RD_W    = 3,
    parameter int unsigned RS_W    = 3
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instr_code;
    logic               out_valid;
    logic               out_ready;
    logic [OP_W-1:0]    opcode;
    logic [RD_W-1:0]    rd;
    logic [RS_W-1:0]    rs;

    modport master (
        output in_valid,
        output instr_code,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  opcode,
        input  rd,
        input  rs
    );

    modport slave (
        input  in_valid,
        input  instr_code,
        input  out_ready,
        output in_ready,
        output out_valid,
        output opcode,
        output rd,
        output rs
    );
endinterface

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with decoded opcode/rd/rs outputs and a saturating flush counter.
// Define IF_ID_SKID_EN for a two-entry skid buffer with registered in_ready.
module if_id_pipe_reg #(
    parameter int unsigned     INSTR_W = 8,
    parameter int unsigned     OP_W    = 2,
    parameter int unsigned     RD_W    = 3,
    parameter int unsigned     RS_W    = 3,
    parameter logic [OP_W-1:0] NOP_OP  = 2'b10,
    parameter int unsigned     CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    if_id_pipe_reg_if.slave  bus,
    output logic [CNT_W-1:0] flush_cnt
);

    if (OP_W + RD_W + RS_W != INSTR_W) begin : g_bad_field_widths
        $error("if_id_pipe_reg: OP_W + RD_W + RS_W must equal INSTR_W");
    end

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } state_e;

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] head_q, head_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               out_valid;
    logic               in_fire;
    logic               out_fire;

    assign out_valid = (state_q != StEmpty);
    assign out_fire  = out_valid & bus.out_ready;
    assign in_fire   = bus.in_valid & bus.in_ready;

`ifdef IF_ID_SKID_EN
    logic [INSTR_W-1:0] skid_q, skid_d;
    logic               in_ready_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            // Flush wins over any transfer; a word accepted this cycle is dropped.
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_d = StOne;
                        head_d  = bus.instr_code;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        head_d = bus.instr_code;
                    end else if (in_fire) begin
                        state_d = StTwo;
                        skid_d  = bus.instr_code;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (out_fire) begin
                        state_d = StOne;
                        head_d  = skid_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            skid_q     <= skid_d;
            // Registered so that in_ready has no combinational path from out_ready.
            in_ready_q <= (state_d != StTwo);
        end
    end

    assign bus.in_ready = in_ready_q;
`else
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_d = StOne;
                        head_d  = bus.instr_code;
                    end
                end
                StOne: begin
                    // With a single entry, in_fire here implies out_fire.
                    if (in_fire) begin
                        head_d = bus.instr_code;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    assign bus.in_ready = bus.out_ready | ~out_valid;
`endif

    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            head_q      <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Bubble fields are forced whenever the register is empty, including during reset.
    always_comb begin
        bus.opcode = NOP_OP;
        bus.rd     = '0;
        bus.rs     = '0;
        if (out_valid) begin
            bus.opcode = head_q[INSTR_W-1 -: OP_W];
            bus.rd     = head_q[INSTR_W-OP_W-1 -: RD_W];
            bus.rs     = head_q[RS_W-1:0];
        end
    end

    assign bus.out_valid = out_valid;
    assign flush_cnt     = flush_cnt_q;

    a_head_stable_on_stall: assert property (
        @(posedge clk) disable iff (!rst_n)
        (out_valid && !bus.out_ready && !flush) |=> $stable(head_q)
    );

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed bench for if_id_pipe_reg: vector table plus hand-written reset, backpressure,
// flush and counter-saturation sequences. Works with IF_ID_SKID_EN defined or not.
module tb_if_id_pipe_reg;

`ifdef IF_ID_SKID_EN
    localparam bit SkidMode = 1'b1;
`else
    localparam bit SkidMode = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [7:0] flush_cnt;

    if_id_pipe_reg_if #(.INSTR_W(8), .OP_W(2), .RD_W(3), .RS_W(3)) bus ();

    if_id_pipe_reg #(
        .INSTR_W(8),
        .OP_W   (2),
        .RD_W   (3),
        .RS_W   (3),
        .NOP_OP (2'b10),
        .CNT_W  (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .bus      (bus),
        .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       fl;
        logic       iv;
        logic [7:0] ic;
        logic       ordy;
        logic       ov;
        logic       ir_skid;
        logic       ir_plain;
        logic [1:0] op;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ov, input logic ir, input logic [1:0] op,
                           input logic [2:0] rd, input logic [2:0] rs, input logic [7:0] cnt);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
        chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(ir));
        chk({tag, ".opcode"},    32'(bus.opcode),    32'(op));
        chk({tag, ".rd"},        32'(bus.rd),        32'(rd));
        chk({tag, ".rs"},        32'(bus.rs),        32'(rs));
        chk({tag, ".flush_cnt"}, 32'(flush_cnt),     32'(cnt));
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [7:0] ic, input logic ordy);
        flush          = fl;
        bus.in_valid   = iv;
        bus.instr_code = ic;
        bus.out_ready  = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_cnt;

        //            fl    iv    ic     ordy  ov    ir_s  ir_p  op     rd    rs    cnt
        vecs[0]  = '{1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 3'd3, 3'd2, 8'd0};
        vecs[1]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 3'd7, 3'd4, 8'd0};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 3'd0, 3'd0, 8'd0};
        vecs[3]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 3'd4, 3'd5, 8'd0};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 3'd4, 3'd5, 8'd0};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 3'd0, 3'd0, 8'd0};
        vecs[6]  = '{1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 3'd0, 3'd0, 8'd1};
        vecs[7]  = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 3'd7, 3'd7, 8'd1};
        vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 3'd0, 3'd0, 8'd2};
        vecs[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 8'd2};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 3'd0, 3'd0, 8'd2};

        // Reset state while rst_n is held low.
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        chk_out("reset_hold", 1'b0, 1'b1, 2'b10, 3'd0, 3'd0, 8'd0);
        #1 rst_n = 1'b1;

        // Load a flush count and a head word, then drop rst_n between edges.
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        drive(1'b0, 1'b1, 8'h5A, 1'b0);
        tick();
        chk("pre_reset.out_valid", 32'(bus.out_valid), 32'd1);
        chk("pre_reset.flush_cnt", 32'(flush_cnt), 32'd1);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk_out("async_reset", 1'b0, 1'b1, 2'b10, 3'd0, 3'd0, 8'd0);
        #1 rst_n = 1'b1;

        // Table: streaming, stall/hold, flush with discarded word, refill after reset.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].fl, vecs[i].iv, vecs[i].ic, vecs[i].ordy);
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].ov,
                    SkidMode ? vecs[i].ir_skid : vecs[i].ir_plain,
                    vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].cnt);
        end
        exp_cnt = 8'd2;

`ifdef IF_ID_SKID_EN
        // Fill both entries under backpressure, then drain in order.
        drive(1'b0, 1'b1, 8'h5A, 1'b0);
        tick();
        chk_out("skid_one", 1'b1, 1'b1, 2'b01, 3'd3, 3'd2, exp_cnt);
        drive(1'b0, 1'b1, 8'h3C, 1'b0);
        tick();
        chk_out("skid_two", 1'b1, 1'b0, 2'b01, 3'd3, 3'd2, exp_cnt);
        drive(1'b0, 1'b1, 8'hFF, 1'b0);
        tick();
        chk_out("skid_two_refuse", 1'b1, 1'b0, 2'b01, 3'd3, 3'd2, exp_cnt);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        chk_out("skid_drain1", 1'b1, 1'b1, 2'b00, 3'd7, 3'd4, exp_cnt);
        tick();
        chk_out("skid_drain2", 1'b0, 1'b1, 2'b10, 3'd0, 3'd0, exp_cnt);

        // Flush from TWO with a word offered: everything is discarded.
        drive(1'b0, 1'b1, 8'h5A, 1'b0);
        tick();
        drive(1'b0, 1'b1, 8'h3C, 1'b0);
        tick();
        chk("flush_pre.in_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 1'b1, 8'hFF, 1'b0);
        tick();
        exp_cnt = exp_cnt + 8'd1;
        chk_out("flush_two", 1'b0, 1'b1, 2'b10, 3'd0, 3'd0, exp_cnt);
`else
        // in_ready follows out_ready combinationally while a word is held.
        drive(1'b0, 1'b1, 8'h5A, 1'b0);
        tick();
        chk_out("plain_stall", 1'b1, 1'b0, 2'b01, 3'd3, 3'd2, exp_cnt);
        bus.out_ready = 1'b1;
        #1;
        chk("plain_ready_comb", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b0;
        #1;
        chk("plain_ready_comb_low", 32'(bus.in_ready), 32'd0);

        // Flush with a word accepted in the same cycle.
        drive(1'b1, 1'b1, 8'h3C, 1'b1);
        tick();
        exp_cnt = exp_cnt + 8'd1;
        chk_out("flush_one", 1'b0, 1'b1, 2'b10, 3'd0, 3'd0, exp_cnt);
`endif
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        chk_out("flush_word_lost", 1'b0, 1'b1, 2'b10, 3'd0, 3'd0, exp_cnt);

        // Hold flush for 300 cycles; the counter must stop at all-ones.
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        for (int c = 0; c < 300; c++) begin
            tick();
            exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
            if (c == 99) chk("sat_mid", 32'(flush_cnt), 32'(exp_cnt));
        end
        chk("sat_end", 32'(flush_cnt), 32'hFF);
        chk("sat_model", 32'(flush_cnt), 32'(exp_cnt));
        drive(1'b0, 1'b1, 8'h5A, 1'b1);
        tick();
        chk_out("sat_hold", 1'b1, 1'b1, 2'b01, 3'd3, 3'd2, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
